instr_fetch_stage: RTL and testbench

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

---
 rtl/instr_fetch_stage.sv | 97 +++++++++
 tb/tb_instr_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: sequential PC generator, single-cycle-latency imem
// interface and a 2-entry {instr, pc} skid FIFO feeding decode.
module instr_fetch_stage #(
  parameter logic [19:0] RESET_PC = 20'h00000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_rd_en,
  output logic [4:0]  imem_addr,
  input  logic [19:0] imem_rd_data,
  input  logic        redirect_valid,
  input  logic [19:0] redirect_pc,
  input  logic        halt,
  output logic        instr_valid,
  output logic [19:0] instr,
  output logic [19:0] instr_pc,
  input  logic        decode_ready
);

  localparam int Depth = 2;

  logic [19:0] pc;
  logic [19:0] inflightPc;
  logic        inflight;
  logic        squash;

  logic [19:0] fifoInstr [Depth];
  logic [19:0] fifoPc    [Depth];
  logic        headIdx;
  logic [1:0]  fifoCount;

  logic        pop;
  logic        push;
  logic        issue;
  logic        wrIdx;
  logic [2:0]  occupancy;

  assign instr_valid = (fifoCount != 2'd0);
  assign instr       = fifoInstr[headIdx];
  assign instr_pc    = fifoPc[headIdx];

  assign pop  = instr_valid && decode_ready;
  assign push = inflight && !squash;

  // Buffered words plus the one still in the memory pipe, after this cycle's pop,
  // must leave room for the response of a new request.
  assign occupancy  = {1'b0, fifoCount} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = rst_n && !halt && !redirect_valid && (occupancy < 3'd2);
  assign imem_rd_en = issue;
  assign imem_addr  = pc[4:0];

  // With two slots the tail is the head when empty and the other slot otherwise.
  assign wrIdx = headIdx ^ fifoCount[0];

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would let pop/push see updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= 20'd0;
      squash     <= 1'b0;
      headIdx    <= 1'b0;
      fifoCount  <= 2'd0;
      // NOTE: the two FIFO slots are reset because they drive instr/instr_pc
      // directly, which must read zero during reset; deeper storage would not be.
      for (int i = 0; i < Depth; i++) begin
        fifoInstr[i] <= 20'd0;
        fifoPc[i]    <= 20'd0;
      end
    end else if (redirect_valid) begin
      // Redirect wins over pop, issue and halt; the response arriving on this
      // edge belongs to the old stream and is dropped.
      pc        <= redirect_pc;
      headIdx   <= 1'b0;
      fifoCount <= 2'd0;
      inflight  <= 1'b0;
      squash    <= inflight;
    end else begin
      squash <= 1'b0;
      if (push) begin
        fifoInstr[wrIdx] <= imem_rd_data;
        fifoPc[wrIdx]    <= inflightPc;
      end
      if (pop) begin
        headIdx <= ~headIdx;
      end
      fifoCount <= fifoCount + {1'b0, push} - {1'b0, pop};
      inflight  <= issue;
      if (issue) begin
        inflightPc <= pc;
        pc         <= pc + 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed vector table, hand-written
// redirect/wrap/halt/reset sequences, then random traffic against a queue model.
module tb_instr_fetch_stage;

  localparam logic [19:0] RESET_PC = 20'h00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_rd_en;
  logic [4:0]  imem_addr;
  logic [19:0] imem_rd_data;
  logic        redirect_valid;
  logic [19:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic [19:0] instr;
  logic [19:0] instr_pc;
  logic        decode_ready;

  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rd_data   (imem_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .decode_ready   (decode_ready)
  );

  // Instruction memory: address registered on the request edge, data valid the cycle after.
  logic [19:0] mem [32];
  logic [4:0]  rd_addr_q;
  assign imem_rd_data = mem[rd_addr_q];
  always @(posedge clk) if (imem_rd_en) rd_addr_q <= imem_addr;

  // Reference model: a queue of delivered-but-unconsumed words and one pending read.
  typedef struct {
    logic [19:0] instr;
    logic [19:0] pc;
  } entry_t;

  entry_t      model_q[$];
  logic [19:0] model_pc;
  logic        model_pend;
  logic [19:0] model_pend_pc;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        halt;
    logic        dr;
    logic        exp_rd;
    logic [4:0]  exp_addr;
    logic        exp_valid;
    logic [19:0] exp_pc;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_pc      = RESET_PC;
    model_pend    = 1'b0;
    model_pend_pc = 20'd0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against the
  // model, then advance the model across the coming rising edge.
  task automatic cycle(input logic h, input logic dr, input logic rv, input logic [19:0] rpc);
    bit exp_valid;
    bit pop;
    bit exp_rd;
    int occ;
    @(negedge clk);
    halt           = h;
    decode_ready   = dr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    exp_valid = (model_q.size() != 0);
    pop       = exp_valid && dr;
    occ       = model_q.size() + int'(model_pend) - int'(pop);
    exp_rd    = !h && !rv && (occ < 2);
    check("imem_rd_en", {31'd0, imem_rd_en}, {31'd0, exp_rd});
    check("imem_addr", {27'd0, imem_addr}, {27'd0, model_pc[4:0]});
    check("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check("instr", {12'd0, instr}, {12'd0, model_q[0].instr});
      check("instr_pc", {12'd0, instr_pc}, {12'd0, model_q[0].pc});
    end
    if (rv) begin
      model_q.delete();
      model_pend = 1'b0;
      model_pc   = rpc;
    end else begin
      if (pop) void'(model_q.pop_front());
      if (model_pend) model_q.push_back('{mem[model_pend_pc[4:0]], model_pend_pc});
      model_pend = exp_rd;
      if (exp_rd) begin
        model_pend_pc = model_pc;
        model_pc      = model_pc + 20'd1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, {31'd0, imem_rd_en}, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"}, {12'd0, instr}, 32'd0);
    check({tag, "_instr_pc"}, {12'd0, instr_pc}, 32'd0);
  endtask

  // Asynchronous assertion mid-cycle, held across two rising edges, released away from an edge.
  task automatic async_reset(input bit refill);
    @(posedge clk);
    #2;
    rst_n          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    decode_ready   = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    if (refill) for (int i = 0; i < 32; i++) mem[i] = 20'($urandom);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] p;
    logic [4:0]  a;
    bit          h;
    bit          dr;
    bit          rv;
    logic [19:0] rpc;

    // Streaming then 5 cycles of backpressure from the first valid cycle.
    //           halt  dr    rd    addr   valid pc
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 20'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 5'd1,  1'b0, 20'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 20'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 20'h0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 20'h0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 20'h0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 20'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 5'd2,  1'b1, 20'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'd3,  1'b1, 20'h1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 5'd4,  1'b1, 20'h2};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 5'd5,  1'b1, 20'h3};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 5'd6,  1'b1, 20'h4};

    for (int i = 0; i < 32; i++) mem[i] = 20'h100 + 20'(i);
    rst_n          = 1'b0;
    halt           = 1'b0;
    decode_ready   = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 20'd0;
    model_reset();
    #1;
    check_reset_outputs("power_on_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].halt, vecs[i].dr, 1'b0, 20'd0);
      check("vec_rd_en", {31'd0, imem_rd_en}, {31'd0, vecs[i].exp_rd});
      check("vec_addr", {27'd0, imem_addr}, {27'd0, vecs[i].exp_addr});
      check("vec_valid", {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check("vec_instr_pc", {12'd0, instr_pc}, {12'd0, vecs[i].exp_pc});
        check("vec_instr", {12'd0, instr}, {12'd0, 20'h100 + vecs[i].exp_pc});
      end
    end

    // Redirect with one word buffered and one read in flight.
    cycle(1'b0, 1'b1, 1'b1, 20'h00017);
    check("redir_rd_en_blocked", {31'd0, imem_rd_en}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 20'd0);
    check("redir_flush_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_resume_rd_en", {31'd0, imem_rd_en}, 32'd1);
    check("redir_resume_addr", {27'd0, imem_addr}, 32'h17);
    for (int k = 0; k < 6 && !instr_valid; k++) cycle(1'b0, 1'b1, 1'b0, 20'd0);
    check("redir_valid_seen", {31'd0, instr_valid}, 32'd1);
    check("redir_first_pc", {12'd0, instr_pc}, 32'h17);
    check("redir_first_instr", {12'd0, instr}, 32'h117);

    // Address wrap at 31 -> 0 while the pc keeps counting.
    cycle(1'b0, 1'b1, 1'b1, 20'h0001E);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 20'd0);
      if (k < 4) begin
        a = 5'd30 + 5'(k);
        check("wrap_addr", {27'd0, imem_addr}, {27'd0, a});
        check("wrap_rd_en", {31'd0, imem_rd_en}, 32'd1);
      end
      if (k >= 2) begin
        check("wrap_valid", {31'd0, instr_valid}, 32'd1);
        check("wrap_instr_pc", {12'd0, instr_pc}, 32'h1E + 32'(k - 2));
      end
    end

    // Full 20-bit pc wrap.
    cycle(1'b0, 1'b1, 1'b1, 20'hFFFFF);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 20'd0);
      if (k == 2) check("pcwrap_top", {12'd0, instr_pc}, 32'hFFFFF);
      if (k == 3) check("pcwrap_zero", {12'd0, instr_pc}, 32'h00000);
    end

    // Halt mid-stream: the in-flight word still arrives, then the stage goes idle.
    p = model_q[0].pc;
    cycle(1'b1, 1'b1, 1'b0, 20'd0);
    check("halt_rd_en", {31'd0, imem_rd_en}, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 20'd0);
    check("halt_inflight_valid", {31'd0, instr_valid}, 32'd1);
    check("halt_inflight_pc", {12'd0, instr_pc}, {12'd0, p + 20'd1});
    cycle(1'b1, 1'b1, 1'b0, 20'd0);
    check("halt_idle_valid", {31'd0, instr_valid}, 32'd0);
    check("halt_idle_rd_en", {31'd0, imem_rd_en}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 20'd0);
    check("resume_rd_en", {31'd0, imem_rd_en}, 32'd1);
    check("resume_addr", {27'd0, imem_addr}, {27'd0, 5'(p + 20'd2)});
    for (int k = 0; k < 6 && !instr_valid; k++) cycle(1'b0, 1'b1, 1'b0, 20'd0);
    check("resume_valid_seen", {31'd0, instr_valid}, 32'd1);
    check("resume_pc", {12'd0, instr_pc}, {12'd0, p + 20'd2});

    // Fill the FIFO, then reset asynchronously.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 20'd0);
    check("full_depth", 32'(model_q.size()), 32'd2);
    async_reset(1'b1);
    cycle(1'b0, 1'b1, 1'b0, 20'd0);
    check("post_reset_rd_en", {31'd0, imem_rd_en}, 32'd1);
    check("post_reset_addr", {27'd0, imem_addr}, {27'd0, RESET_PC[4:0]});
    for (int k = 0; k < 6 && !instr_valid; k++) cycle(1'b0, 1'b1, 1'b0, 20'd0);
    check("post_reset_pc", {12'd0, instr_pc}, {12'd0, RESET_PC});

    // Random traffic against the model, with occasional redirects and resets.
    for (int n = 0; n < 600; n++) begin
      h   = ($urandom_range(0, 9) < 2);
      dr  = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 20'hFFFFE : 20'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset(1'b0);
      else cycle(h, dr, rv, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
